// File: rtl/whack_pkg.sv
// whack_pkg: shared types and defaults for the whack-a-mole input front-end
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } chord_state_t;

    localparam int NUM_BTN_DEF      = 8;
    localparam int DEBOUNCE_DEF     = 16;
    localparam int CHORD_WINDOW_DEF = 64;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-FF synchroniser, stable-count debouncer and edge pulses for one button
module debounce_channel import whack_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic press,
    output logic released
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic s1, s2, press_q, release_q;
    logic [CW-1:0] cnt;

    // Pulses are held (not cleared) while disabled so an event is not lost across an ena gap
    assign press    = ena & press_q;
    assign released = ena & release_q;

    // Synchronise, count consecutive differing samples, accept level after DEBOUNCE_CYCLES of them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else if (ena) begin
            s1        <= raw;
            s2        <= s1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt       <= '0;
                level     <= s2;
                press_q   <= s2;
                release_q <= ~s2;
            end
        end
    end

endmodule

// File: rtl/btn_input_frontend.sv
// btn_input_frontend: per-button debounce plus chord capture FSM feeding the game logic
module btn_input_frontend import whack_pkg::*; #(
    parameter int NUM_BTN         = NUM_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CHORD_WINDOW    = CHORD_WINDOW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] chord,
    output logic               chord_valid,
    output logic               busy
);
    localparam int TW = $clog2(CHORD_WINDOW + 1);
    localparam logic [TW-1:0] TIMER_INIT = TW'(CHORD_WINDOW - 1);

    chord_state_t state;
    logic [NUM_BTN-1:0] acc;
    logic [TW-1:0] timer;
    logic valid_q;

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_ch
            debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .ena      (ena),
                .raw      (btn_raw[i]),
                .level    (btn_level[i]),
                .press    (btn_press[i]),
                .released (btn_release[i])
            );
        end
    endgenerate

    assign busy        = state != IDLE;
    assign chord_valid = ena & valid_q;

    // Collect presses for CHORD_WINDOW cycles after the first, report, then wait for full release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            timer   <= '0;
            chord   <= '0;
            valid_q <= 1'b0;
        end else if (ena) begin
            valid_q <= 1'b0;
            case (state)
                IDLE: if (|btn_press) begin
                    acc   <= btn_press;
                    timer <= TIMER_INIT;
                    state <= COLLECT;
                end
                COLLECT: begin
                    acc <= acc | btn_press;
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        chord   <= acc | btn_press;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: if (btn_level == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_input_frontend.sv
// tb_btn_input_frontend: random and directed stimulus checked against a run-length/window model
module tb_btn_input_frontend;
    localparam int N = 8;
    localparam int D = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, chord;
    logic chord_valid, busy;

    int n_tests = 0;
    int n_fail = 0;
    int vcount = 0;

    logic [N-1:0] m_level, m_press, m_release, m_chord, acc;
    logic m_valid;
    int run[N];
    logic [N-1:0] hist[$];
    int phase, start, t;

    btn_input_frontend #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D), .CHORD_WINDOW(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .chord       (chord),
        .chord_valid (chord_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = '0; m_press = '0; m_release = '0; m_chord = '0; m_valid = 1'b0;
        acc = '0; phase = 0; start = 0; t = 0;
        foreach (run[k]) run[k] = 0;
        hist = {};
        hist.push_back('0);
        hist.push_back('0);
    endtask

    // Level flips once a channel has seen D consecutive synchronised samples differing from it;
    // the chord reports on the W-th enabled cycle after the one that saw the first press.
    task automatic model_step();
        logic [N-1:0] s2;
        if (!rst_n || !ena) return;
        t++;
        m_valid = 1'b0;
        if (phase == 0) begin
            if (m_press != 0) begin
                phase = 1; start = t; acc = m_press;
            end
        end else if (phase == 1) begin
            acc |= m_press;
            if (t == start + W) begin
                m_chord = acc; m_valid = 1'b1; phase = 2;
            end
        end else if (m_level == 0) begin
            phase = 0;
        end
        s2 = hist.pop_front();
        hist.push_back(btn_raw);
        m_press = '0;
        m_release = '0;
        for (int k = 0; k < N; k++) begin
            run[k] = (s2[k] != m_level[k]) ? run[k] + 1 : 0;
            if (run[k] == D) begin
                run[k] = 0;
                m_level[k] = s2[k];
                m_press[k] = s2[k];
                m_release[k] = ~s2[k];
            end
        end
    endtask

    task automatic compare_all();
        chk("level", btn_level, m_level);
        chk("press", btn_press, ena ? m_press : '0);
        chk("release", btn_release, ena ? m_release : '0);
        chk("chord", chord, m_chord);
        chk("chord_valid", chord_valid, ena & m_valid);
        chk("busy", busy, phase != 0);
    endtask

    task automatic tick(input logic [N-1:0] r, input logic e);
        btn_raw = r;
        ena = e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chord_valid) vcount++;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_level", btn_level, 0);
        chk("rst_chord", chord, 0);
        chk("rst_valid", chord_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_press", btn_press | btn_release, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] target, r;
        model_reset();
        @(negedge clk);
        do_reset();

        // debounced press of bit 3 lands on edge D+2
        for (int c = 1; c <= 5; c++) tick(8'h08, 1'b1);
        chk("s2_level_early", btn_level, 0);
        tick(8'h08, 1'b1);
        chk("s2_level", btn_level, 8'h08);
        chk("s2_press", btn_press, 8'h08);
        tick(8'h08, 1'b1);
        chk("s2_press_once", btn_press, 0);
        for (int c = 1; c <= 5; c++) tick(8'h00, 1'b1);
        chk("s2_release_early", btn_release, 0);
        tick(8'h00, 1'b1);
        chk("s2_release", btn_release, 8'h08);
        chk("s2_level_low", btn_level, 0);
        for (int c = 0; c < 20; c++) tick(8'h00, 1'b1);

        // short glitch is rejected
        vcount = 0;
        for (int c = 0; c < 3; c++) tick(8'h01, 1'b1);
        for (int c = 0; c < 12; c++) begin
            tick(8'h00, 1'b1);
            chk("glitch_level", btn_level | btn_press, 0);
        end
        chk("glitch_valid", vcount, 0);

        // two-button chord, extra press ignored in HOLD, then fresh chord
        vcount = 0;
        for (int c = 0; c < 3; c++) tick(8'h02, 1'b1);
        for (int c = 0; c < 20; c++) tick(8'h12, 1'b1);
        chk("chord4_cnt", vcount, 1);
        chk("chord4_val", chord, 8'h12);
        for (int c = 0; c < 20; c++) tick(8'h52, 1'b1);
        chk("chord4_hold_cnt", vcount, 1);
        for (int c = 0; c < 12; c++) tick(8'h00, 1'b1);
        for (int c = 0; c < 24; c++) tick(8'h04, 1'b1);
        chk("chord4b_cnt", vcount, 2);
        chk("chord4b_val", chord, 8'h04);
        for (int c = 0; c < 12; c++) tick(8'h00, 1'b1);

        // window edges: second press lands at offsets 7..10 after the first
        for (int off = 7; off <= 10; off++) begin
            for (int c = 0; c < off; c++) tick(8'h01, 1'b1);
            for (int c = 0; c < 16; c++) tick(8'h21, 1'b1);
            chk("window_edge", chord, (off <= 8) ? 8'h21 : 8'h01);
            for (int c = 0; c < 12; c++) tick(8'h00, 1'b1);
        end

        // ena gap mid-COLLECT delays the report
        for (int c = 0; c < 8; c++) tick(8'h20, 1'b1);
        for (int c = 0; c < 5; c++) tick(8'h20, 1'b0);
        for (int c = 0; c < 16; c++) tick(8'h20, 1'b1);
        for (int c = 0; c < 12; c++) tick(8'h00, 1'b1);

        // reset mid-COLLECT discards the chord
        for (int c = 0; c < 8; c++) tick(8'h80, 1'b1);
        chk("mid_busy", busy, 1);
        do_reset();
        vcount = 0;
        for (int c = 0; c < 20; c++) tick(8'h00, 1'b1);
        chk("mid_rst_valid", vcount, 0);

        // random traffic
        target = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 30 == 0) target = ($urandom % 3 == 0) ? '0 : N'($urandom);
            r = target;
            if ($urandom % 10 == 0) r ^= N'(1 << ($urandom % N));
            tick(r, ($urandom % 16) != 0);
            if ($urandom % 1000 == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_input_frontend.md
# btn_input_frontend

Button input front-end for the whack-a-mole design: synchronises the raw `ui_in` button pins, debounces each channel, and produces clean level, press and release signals plus a captured multi-button "chord". It feeds the game FSM, which consumes the debounced level and the chord report in place of raw pins. It is the input-side counterpart of the pattern/7-seg output path: the display shows a pattern, and this block delivers the player's response.

## Interface
Parameters:
- `NUM_BTN`, 8: number of button channels.
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples required to accept a level change; must be ≥ 2.
- `CHORD_WINDOW`, 64: collection window, in cycles, after the first press of a chord; must be ≥ 1.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: block enable; low freezes all state.
- `btn_raw`  in  NUM_BTN: raw, asynchronous, active-high button pins.
- `btn_level`  out  NUM_BTN: debounced button level.
- `btn_press`  out  NUM_BTN: one-cycle pulse per channel on a debounced 0→1 transition.
- `btn_release`  out  NUM_BTN: one-cycle pulse per channel on a debounced 1→0 transition.
- `chord`  out  NUM_BTN: OR of all presses in the last completed window; held until the next report.
- `chord_valid`  out  1: one-cycle pulse when `chord` updates.
- `busy`  out  1: high while the FSM is in COLLECT or HOLD.

## Operation
- **Reset:** all flops clear. Every output is 0, and the FSM enters IDLE.
- **Synchroniser:** 2-FF chain per channel. Only the second stage (`s2`) is used downstream.
- **Debounce (per channel):**
  - The channel has a counter of width $clog2(DEBOUNCE_CYCLES) and a `level` flop.
  - If `s2 == level`, the counter is cleared.
  - If `s2 != level` and the counter is below DEBOUNCE_CYCLES-1, the counter increments.
  - If `s2 != level` and the counter equals DEBOUNCE_CYCLES-1, `level` takes `s2` and the counter clears.
  - Any bounce back to `level` restarts the count from 0.
- **Press/release:** both are registered. `btn_press[i]` is high in exactly the first cycle that the new `btn_level[i]` is 1, and `btn_release[i]` likewise on a fall. Different channels are independent, and simultaneous events on several channels are reported in the same cycle.
- **Chord FSM** (states IDLE, COLLECT, HOLD):
  - IDLE: if `|btn_press`, set `acc` to `btn_press`, set `timer` to CHORD_WINDOW-1, and go to COLLECT.
  - COLLECT: `acc |= btn_press` every cycle.
    - If `timer != 0`, decrement it.
    - If `timer == 0`: `chord` takes `acc | btn_press`, pulse `chord_valid`, and go to HOLD.
  - HOLD: presses are ignored. When `btn_level == 0`, go to IDLE. The transition happens even in the same cycle as a new press; that press is lost, which is intentional because it forces a full release between chords.
- **ena low:**
  - All synchroniser, debounce, FSM and `chord` state holds.
  - `btn_press`, `btn_release` and `chord_valid` are forced to 0.
  - `btn_level`, `chord` and `busy` keep their values.
  - Normal operation resumes on the first cycle with `ena` high.
- **Reset mid-operation:** an in-progress chord is discarded, and no `chord_valid` is emitted.

## Timing
- Clock edge numbering: a pin change is first sampled at edge 1. It reaches `s2` at edge 2.
- `btn_level` and `btn_press` (or `btn_release`) update at edge DEBOUNCE_CYCLES+2, provided the pin stays stable.
  - A glitch shorter than DEBOUNCE_CYCLES samples at `s2` never changes the level.
- Chord timing, with the first press visible in cycle P:
  - The FSM enters COLLECT at edge P+1.
  - `chord_valid` is high in cycle P+CHORD_WINDOW+1.
  - Presses visible in cycles P through P+CHORD_WINDOW are included.
- `chord_valid` and `btn_press` never assert for more than one consecutive cycle on the same event.

## Structure
- Shared package `whack_pkg`:
  - FSM state enum `chord_state_t` (IDLE, COLLECT, HOLD).
  - Defaults `NUM_BTN_DEF = 8`, `DEBOUNCE_DEF = 16`, `CHORD_WINDOW_DEF = 64`.
- Sub-module `debounce_channel`: 1-bit synchroniser, counter and level, producing `level`, `press` and `release`. The top instantiates NUM_BTN copies via generate and holds the chord FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CHORD_WINDOW=8.

1. Assert reset, then release with `btn_raw` = 0x00 → all outputs 0, `busy` = 0.
2. Drive `btn_raw[3]` high and hold it → `btn_level` = 0x08 from edge 6, and `btn_press` = 0x08 for exactly one cycle. Drop the pin → `btn_release` = 0x08 for one cycle, 6 edges later.
3. Pulse bit 0 high for 3 cycles, then low → `btn_level`, `btn_press` and `chord_valid` stay 0.
4. Press bit 1, then bit 4 three cycles later, and hold both → one `chord_valid` pulse with `chord` = 0x12. Press bit 6 while holding → no new report. Release all, then press bit 2 → next report has `chord` = 0x04.
5. A press of bit 5 lands exactly in cycle P+8 (the last window cycle) → it is included in `chord`. A press in cycle P+9 → excluded.
6. Start a chord, then:
   - pull `ena` low for 5 cycles mid-COLLECT → `chord_valid` is delayed by 5 cycles, and `chord` is unchanged;
   - alternatively, assert `rst_n` low mid-COLLECT → no `chord_valid` appears, and all outputs read 0.
